// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared defaults and legal parameter ranges for the debounce
//               bank and its per-channel slice, plus a prescaler width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Default parameter values
    localparam int DEF_CH          = 4;
    localparam int DEF_CNT_BITS    = 14;
    localparam int DEF_PRESCALE    = 1;
    localparam int DEF_HOLD_BITS   = 8;
    localparam int DEF_RESET_LEVEL = 0;

    // Legal parameter ranges (inclusive)
    localparam int CH_MIN        = 1;
    localparam int CH_MAX        = 32;
    localparam int CNT_BITS_MIN  = 2;
    localparam int CNT_BITS_MAX  = 20;
    localparam int PRESCALE_MIN  = 1;
    localparam int PRESCALE_MAX  = 65535;
    localparam int HOLD_BITS_MIN = 2;
    localparam int HOLD_BITS_MAX = 16;

    // Width of a counter running 0..p-1. A divide-by-one prescaler still
    // gets a one-bit register so the port/compare widths never collapse.
    function automatic int ps_width(input int p);
        int v;
        v = (p > PRESCALE_MAX) ? PRESCALE_MAX : p;
        if (v <= 1) begin
            return 1;
        end
        return $clog2(v);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : debounce_chan
// Description : One debounce channel: 2-flop synchronizer, history pair,
//               stability counter, long-press counter and registered
//               clean/rise/fall/hold outputs.
// Ports       : clk, reset (sync, active-high), tick (shared prescaler
//               strobe), pb (raw level) -> clean_pb, rise, fall, hold.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int CNT_BITS    = DEF_CNT_BITS,
    parameter int HOLD_BITS   = DEF_HOLD_BITS,
    parameter int RESET_LEVEL = DEF_RESET_LEVEL
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pb,
    output logic clean_pb,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam logic c_rst_lvl = (RESET_LEVEL != 0);
    localparam logic [CNT_BITS-1:0]  c_cnt_one  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [HOLD_BITS-1:0] c_hold_one = {{(HOLD_BITS-1){1'b0}}, 1'b1};

    // r_sync_q[1] is the synchronized bit s; r_sdly_q is its delayed copy.
    logic [1:0]           r_sync_q,   w_sync_d;
    logic                 r_sdly_q,   w_sdly_d;
    logic [CNT_BITS-1:0]  r_count_q,  w_count_d;
    logic [HOLD_BITS-1:0] r_hcount_q, w_hcount_d;
    logic                 r_clean_q,  w_clean_d;
    logic                 r_rise_q,   w_rise_d;
    logic                 r_fall_q,   w_fall_d;
    logic                 r_hold_q,   w_hold_d;

    always_comb begin
        w_sync_d   = {r_sync_q[0], pb};
        w_sdly_d   = r_sync_q[1];
        w_count_d  = r_count_q;
        w_clean_d  = r_clean_q;
        w_hcount_d = r_hcount_q;

        // Any history mismatch restarts the full stability interval; once
        // saturated the counter simply keeps the clean level tracking s_d.
        if (r_sync_q[1] != r_sdly_q) begin
            w_count_d = '0;
        end else if (&r_count_q) begin
            w_clean_d = r_sdly_q;
        end else if (tick) begin
            w_count_d = r_count_q + c_cnt_one;
        end

        // Long-press timer runs only while the current clean level is high.
        if (!r_clean_q) begin
            w_hcount_d = '0;
        end else if (tick && !(&r_hcount_q)) begin
            w_hcount_d = r_hcount_q + c_hold_one;
        end

        // Edge pulses are registered alongside the clean level so they
        // appear in the same cycle as the new value.
        w_rise_d = w_clean_d & ~r_clean_q;
        w_fall_d = ~w_clean_d & r_clean_q;
        w_hold_d = (&w_hcount_d) & ~(&r_hcount_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_q   <= {2{c_rst_lvl}};
            r_sdly_q   <= c_rst_lvl;
            r_clean_q  <= c_rst_lvl;
            r_count_q  <= '0;
            r_hcount_q <= '0;
            r_rise_q   <= 1'b0;
            r_fall_q   <= 1'b0;
            r_hold_q   <= 1'b0;
        end else begin
            r_sync_q   <= w_sync_d;
            r_sdly_q   <= w_sdly_d;
            r_clean_q  <= w_clean_d;
            r_count_q  <= w_count_d;
            r_hcount_q <= w_hcount_d;
            r_rise_q   <= w_rise_d;
            r_fall_q   <= w_fall_d;
            r_hold_q   <= w_hold_d;
        end
    end

    assign clean_pb = r_clean_q;
    assign rise     = r_rise_q;
    assign fall     = r_fall_q;
    assign hold     = r_hold_q;

endmodule : debounce_chan
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank
// Description : Bank of CH independent push-button debouncers sharing one
//               free-running tick prescaler.
// Ports       : clk, reset (sync, active-high), pb[CH] raw levels ->
//               clean_pb[CH], rise[CH], fall[CH], hold[CH] (one-cycle pulses).
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CH          = DEF_CH,
    parameter int CNT_BITS    = DEF_CNT_BITS,
    parameter int PRESCALE    = DEF_PRESCALE,
    parameter int HOLD_BITS   = DEF_HOLD_BITS,
    parameter int RESET_LEVEL = DEF_RESET_LEVEL
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] pb,
    output logic [CH-1:0] clean_pb,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] hold
);

    localparam int                c_ps_w   = ps_width(PRESCALE);
    localparam logic [c_ps_w-1:0] c_ps_max = c_ps_w'(PRESCALE - 1);
    localparam logic [c_ps_w-1:0] c_ps_one = {{(c_ps_w-1){1'b0}}, 1'b1};

    logic [c_ps_w-1:0] r_ps_q, w_ps_d;
    logic              w_tick;

    // With PRESCALE=1 the counter sits at zero and tick is permanently high.
    always_comb begin
        w_tick = (r_ps_q == c_ps_max);
        w_ps_d = w_tick ? '0 : (r_ps_q + c_ps_one);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps_q <= '0;
        end else begin
            r_ps_q <= w_ps_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        debounce_chan #(
            .CNT_BITS    (CNT_BITS),
            .HOLD_BITS   (HOLD_BITS),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .tick     (w_tick),
            .pb       (pb[i]),
            .clean_pb (clean_pb[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .hold     (hold[i])
        );
    end

endmodule : debounce_bank
`default_nettype wire

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CH, default 4, number of independent push-button/switch channels (1..32).
REQ-002 Parameter CNT_BITS, default 14, stability counter width per channel (2..20).
REQ-003 Parameter PRESCALE, default 1, clk cycles per counting tick (1..65535); 1 means a tick every cycle.
REQ-004 Parameter HOLD_BITS, default 8, long-press counter width per channel (2..16).
REQ-005 Parameter RESET_LEVEL, default 0, clean level loaded into every channel at reset.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 pb  input  CH  raw asynchronous button levels.
REQ-009 clean_pb  output  CH  debounced level per channel.
REQ-010 rise  output  CH  one-cycle pulse when clean_pb goes 0->1.
REQ-011 fall  output  CH  one-cycle pulse when clean_pb goes 1->0.
REQ-012 hold  output  CH  one-cycle pulse when the channel has been continuously high for a full hold period.

Function
REQ-013 Each pb bit SHALL pass through a 2-flop synchronizer; the synchronized bit s and its one-cycle-delayed copy s_d SHALL form the history pair.
REQ-014 A shared prescaler SHALL count 0..PRESCALE-1 and assert tick in the cycle it equals PRESCALE-1; it free-runs and is shared by all channels.
REQ-015 Per channel: if s != s_d, count <= 0 regardless of tick; else if count is all-ones, clean_pb <= s_d (no tick needed); else if tick, count <= count+1.
REQ-016 count SHALL saturate at all-ones and stay there until the next history mismatch.
REQ-017 With PRESCALE=1, a level held stable from edge 1 (the first edge sampling it) SHALL appear on clean_pb after edge 2^CNT_BITS+3.
REQ-018 A level change shorter than the latency in REQ-017 SHALL never reach clean_pb; any mismatch restarts the full interval.
REQ-019 rise/fall SHALL be registered and asserted in the same cycle clean_pb shows its new value, for exactly one cycle.
REQ-020 Per channel, hcount (HOLD_BITS) SHALL be 0 while clean_pb is 0, increment on each tick while clean_pb is 1, and saturate at all-ones.
REQ-021 hold SHALL pulse for one cycle in the cycle hcount becomes all-ones; no further hold pulse until clean_pb falls and rises again.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous independent pulses.

Reset
REQ-023 While reset is high: synchronizer flops, s_d, clean_pb <= RESET_LEVEL; count, hcount, prescaler <= 0; rise, fall, hold <= 0.
REQ-024 No rise/fall SHALL occur as a result of reset entry or exit; reset mid-count discards progress, and timing restarts from the first post-reset edge.

Structure
REQ-025 Default parameter values and the legal-range limits SHALL live in a shared package (debounce_pkg) used by top and sub-module.
REQ-026 Per-channel logic (synchronizer, history, count, hcount, clean/rise/fall/hold) SHALL be a sub-module debounce_chan instantiated CH times by a generate loop; the prescaler stays in debounce_bank.

Verification (CH=2, CNT_BITS=4, HOLD_BITS=3, RESET_LEVEL=0, PRESCALE=1 unless stated)
REQ-027 pb[0] 0->1 and held -> clean_pb[0]=1 after edge 19; rise[0] high that cycle only; channel 1 outputs unchanged.
REQ-028 pb[0] toggles every 5 cycles for 40 cycles, then held 1 -> clean_pb[0] stays 0 throughout and rises 19 edges after the last toggle's sampling edge.
REQ-029 After clean_pb[0] rises, pb held -> hold[0] pulses once on the 7th edge after the rise; it does not repeat over 100 further cycles.
REQ-030 PRESCALE=4, pb[0] 0->1 held -> clean_pb[0] rises between edge 61 and edge 64 inclusive, depending on prescaler phase.
REQ-031 Reset pulsed for 1 cycle at edge 10 of a count -> all outputs 0, no rise/fall; clean_pb rises 19 edges after the first post-reset edge.
REQ-032 With clean_pb=2'b10, pb changes to 2'b01 in one cycle -> rise[0] and fall[1] asserted in the same cycle, each for one cycle.
